exit_time_arbiter: RTL



---
 rtl/exit_time_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/exit_time_arbiter.sv
// Shares one duration/fee datapath among N exit gates via a round-robin arbiter.
// Ports: clk, reset (sync, active-high); req / time_in_bus / time_out_bus from
//   the gates; grant one-hot pulse back to the gates; res_valid / res_ready
//   handshake with res_gate, res_duration, res_fee to billing; busy status.
module exit_time_arbiter #(
    parameter int N_GATES = 4,
    parameter int TIME_W  = 8,
    parameter int RATE    = 5,
    parameter int FEE_W   = 16,
    localparam int GW     = (N_GATES > 1) ? $clog2(N_GATES) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_GATES-1:0]          req,
    input  logic [N_GATES*TIME_W-1:0]   time_in_bus,
    input  logic [N_GATES*TIME_W-1:0]   time_out_bus,
    output logic [N_GATES-1:0]          grant,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [GW-1:0]               res_gate,
    output logic [TIME_W-1:0]           res_duration,
    output logic [FEE_W-1:0]            res_fee,
    output logic                        busy
);

    // Wide enough that duration*RATE never overflows before saturation.
    localparam int PROD_W = TIME_W + 32 + FEE_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [GW-1:0]       ptr_q;
    logic [GW-1:0]       win_q;
    logic [TIME_W-1:0]   t_in_q, t_out_q;

    logic                found;
    logic [GW-1:0]       win_c;
    logic [TIME_W-1:0]   dur_c;
    logic [PROD_W-1:0]   prod_c;
    logic [FEE_W-1:0]    fee_c;
    logic [GW-1:0]       ptr_next;

    // First requesting gate at or above the pointer, wrapping around.
    always_comb begin
        found = 1'b0;
        win_c = '0;
        for (int i = 0; i < N_GATES; i++) begin
            int idx;
            idx = (int'(ptr_q) + i) % N_GATES;
            if (!found && req[idx]) begin
                found = 1'b1;
                win_c = GW'(idx);
            end
        end
    end

    // Duration wraps naturally in TIME_W bits; fee clamps to all ones.
    always_comb begin
        dur_c  = t_out_q - t_in_q;
        prod_c = PROD_W'(dur_c) * PROD_W'(RATE);
        if (prod_c > PROD_W'({FEE_W{1'b1}}))
            fee_c = '1;
        else
            fee_c = prod_c[FEE_W-1:0];
    end

    always_comb begin
        if (win_q == GW'(N_GATES - 1))
            ptr_next = '0;
        else
            ptr_next = win_q + GW'(1);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (found)     state_d = CALC;
            CALC:                state_d = DONE;
            DONE: if (res_ready) state_d = IDLE;
            default:             state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant        <= '0;
            res_valid    <= 1'b0;
            res_gate     <= '0;
            res_duration <= '0;
            res_fee      <= '0;
            busy         <= 1'b0;
            ptr_q        <= '0;
            win_q        <= '0;
            t_in_q       <= '0;
            t_out_q      <= '0;
        end else begin
            grant <= '0;
            busy  <= (state_d != IDLE);
            unique case (state_q)
                IDLE: begin
                    if (found) begin
                        grant[win_c] <= 1'b1;
                        win_q        <= win_c;
                        t_in_q       <= time_in_bus[win_c*TIME_W +: TIME_W];
                        t_out_q      <= time_out_bus[win_c*TIME_W +: TIME_W];
                    end
                end
                CALC: begin
                    res_duration <= dur_c;
                    res_fee      <= fee_c;
                    res_gate     <= win_q;
                    res_valid    <= 1'b1;
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        ptr_q     <= ptr_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
